// File: rtl/arm_cond_pkg.sv
// arm_cond_pkg: condition codes, NZCV flag indices and the ID/EX control word
package arm_cond_pkg;
    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef struct packed {
        logic       reg_w;
        logic       mem_w;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       pcs;
        logic [1:0] flag_w;
        cond_e      cond;
    } ex_ctrl_t;
    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{reg_w: 1'b0, mem_w: 1'b0, memtoreg: 1'b0, alusrc: 1'b0,
                                            branch: 1'b0, pcs: 1'b0, flag_w: 2'b00, cond: COND_AL};
endpackage

// File: rtl/ex_cond_stage_if.sv
// ex_cond_stage_if: decoder/hazard inputs and gated execute-stage outputs
interface ex_cond_stage_if #(
    parameter int FLAG_W = 4,
    parameter int ALUC_W = 2
);
    logic              StallE, FlushE;
    logic              RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, PCSD;
    logic [1:0]        FlagWD;
    logic [3:0]        CondD;
    logic [ALUC_W-1:0] ALUControlD;
    logic [FLAG_W-1:0] ALUFlags;
    logic              MemtoRegE, ALUSrcE, CondExE, RegWriteE, MemWriteE, PCSrcE;
    logic [ALUC_W-1:0] ALUControlE;
    logic [FLAG_W-1:0] FlagsE;
    modport master (
        output StallE, FlushE, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, PCSD,
               FlagWD, CondD, ALUControlD, ALUFlags,
        input  MemtoRegE, ALUSrcE, ALUControlE, CondExE, RegWriteE, MemWriteE, PCSrcE, FlagsE
    );
    modport slave (
        input  StallE, FlushE, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, PCSD,
               FlagWD, CondD, ALUControlD, ALUFlags,
        output MemtoRegE, ALUSrcE, ALUControlE, CondExE, RegWriteE, MemWriteE, PCSrcE, FlagsE
    );
endinterface

// File: rtl/ex_cond_stage_cond_check.sv
// cond_check: condition-field evaluation against NZCV; COND_FULL_EN selects all 15 codes, else EQ/NE/AL only
module cond_check
    import arm_cond_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic z;
    assign z = flags[FLAG_Z];
`ifdef COND_FULL_EN
    logic n, c, v;
    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];
    // full condition decode; the NV encoding never executes
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c & !z;
            COND_LS: cond_ex = !c | z;
            COND_GE: cond_ex = n == v;
            COND_LT: cond_ex = n != v;
            COND_GT: cond_ex = !z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = ^{flags[FLAG_N], flags[FLAG_C], flags[FLAG_V]};
    assign cond_ex = (cond == COND_EQ) ? z : (cond == COND_NE) ? !z : (cond == COND_AL);
`endif
endmodule

// File: rtl/ex_cond_stage.sv
// ex_cond_stage: ID/EX control register, NZCV flags and condition gating (COND_FULL_EN: full condition set)
module ex_cond_stage
    import arm_cond_pkg::*;
#(
    parameter int FLAG_W = 4,
    parameter int ALUC_W = 2
) (
    input logic            clk,
    input logic            reset,
    ex_cond_stage_if.slave bus
);
    ex_ctrl_t          ctrl_q, ctrl_d, ctrl_in;
    logic [ALUC_W-1:0] aluc_q, aluc_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              cond_ex;
    assign ctrl_in = '{reg_w: bus.RegWD, mem_w: bus.MemWD, memtoreg: bus.MemtoRegD, alusrc: bus.ALUSrcD,
                       branch: bus.BranchD, pcs: bus.PCSD, flag_w: bus.FlagWD, cond: cond_e'(bus.CondD)};
    cond_check u_cond (.cond(ctrl_q.cond), .flags(flags_q), .cond_ex(cond_ex));
    // next ID/EX word: flush beats stall, stall beats load
    always_comb begin
        ctrl_d = bus.FlushE ? EX_CTRL_BUBBLE : bus.StallE ? ctrl_q : ctrl_in;
        aluc_d = bus.FlushE ? '0 : bus.StallE ? aluc_q : bus.ALUControlD;
    end
    // flags commit only for a passing, non-stalled instruction so a held setter cannot write twice
    always_comb begin
        flags_d = flags_q;
        if (!bus.StallE && cond_ex && ctrl_q.flag_w[1]) flags_d[FLAG_N:FLAG_Z] = bus.ALUFlags[FLAG_N:FLAG_Z];
        if (!bus.StallE && cond_ex && ctrl_q.flag_w[0]) flags_d[FLAG_C:FLAG_V] = bus.ALUFlags[FLAG_C:FLAG_V];
    end
    // state registers; reset leaves an AL bubble and clear flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= EX_CTRL_BUBBLE;
            aluc_q  <= '0;
            flags_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            aluc_q  <= aluc_d;
            flags_q <= flags_d;
        end
    end
    assign bus.MemtoRegE   = ctrl_q.memtoreg;
    assign bus.ALUSrcE     = ctrl_q.alusrc;
    assign bus.ALUControlE = aluc_q;
    assign bus.CondExE     = cond_ex;
    assign bus.RegWriteE   = ctrl_q.reg_w & cond_ex;
    assign bus.MemWriteE   = ctrl_q.mem_w & cond_ex;
    assign bus.PCSrcE      = (ctrl_q.pcs | ctrl_q.branch) & cond_ex;
    assign bus.FlagsE      = flags_q;
endmodule

// File: tb/tb_ex_cond_stage.sv
// tb_ex_cond_stage: scoreboard bench for ex_cond_stage (expectations follow COND_FULL_EN)
module tb_ex_cond_stage;
    import arm_cond_pkg::*;
`ifdef COND_FULL_EN
    localparam logic F = 1'b1;
`else
    localparam logic F = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [11:0] sb[$];
    logic [11:0] ev;
    ex_cond_stage_if bus ();
    ex_cond_stage dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // observed word: {CondExE, RegWriteE, MemWriteE, PCSrcE, FlagsE[3:0], MemtoRegE, ALUSrcE, ALUControlE[1:0]}
    function automatic logic [11:0] obs();
        return {bus.CondExE, bus.RegWriteE, bus.MemWriteE, bus.PCSrcE, bus.FlagsE,
                bus.MemtoRegE, bus.ALUSrcE, bus.ALUControlE};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [3:0] cond, input logic regw, input logic memw, input logic branch,
                         input logic pcs, input logic [1:0] flagw, input logic [3:0] aluf,
                         input logic stall, input logic flush);
        bus.CondD = cond;
        bus.RegWD = regw;
        bus.MemWD = memw;
        bus.BranchD = branch;
        bus.PCSD = pcs;
        bus.FlagWD = flagw;
        bus.ALUFlags = aluf;
        bus.StallE = stall;
        bus.FlushE = flush;
        bus.MemtoRegD = 1'b0;
        bus.ALUSrcD = 1'b0;
        bus.ALUControlD = 2'b00;
    endtask
    task automatic do_reset();
        drive(COND_AL, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
    task automatic test_reset();
        do_reset();
        drive(COND_AL, 1, 1, 1, 0, 2'b11, 4'b0000, 0, 0);
        sb.push_back(12'b1_1_1_1_0000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL pre_reset: got %b want %b", obs(), ev); end
        drive(COND_AL, 1, 1, 1, 0, 2'b11, 4'b1111, 0, 0);
        sb.push_back(12'b1_0_0_0_0000_0_0_00);
        #2 reset = 1'b1;
        #1;
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL reset_async: got %b want %b", obs(), ev); end
        sb.push_back(12'b1_0_0_0_0000_0_0_00);
        tick();
        reset = 1'b0;
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs(), ev); end
        drive(COND_EQ, 1, 0, 0, 0, 2'b00, 4'b0000, 0, 0);
        sb.push_back(12'b0_0_0_0_0000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL post_reset_eq: got %b want %b", obs(), ev); end
    endtask
    task automatic test_back_to_back();
        do_reset();
        drive(COND_AL, 0, 0, 0, 0, 2'b11, 4'b0000, 0, 0);
        sb.push_back(12'b1_0_0_0_0000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL cmp_issue: got %b want %b", obs(), ev); end
        drive(COND_EQ, 1, 1, 0, 0, 2'b00, 4'b0100, 0, 0);
        sb.push_back(12'b1_1_1_0_0100_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL eq_taken: got %b want %b", obs(), ev); end
        drive(COND_NE, 1, 1, 0, 0, 2'b00, 4'b0000, 0, 0);
        sb.push_back(12'b0_0_0_0_0100_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL ne_skipped: got %b want %b", obs(), ev); end
    endtask
    task automatic test_gt_gating();
        do_reset();
        drive(COND_AL, 0, 0, 0, 0, 2'b11, 4'b0000, 0, 0);
        sb.push_back(12'b1_0_0_0_0000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL set_issue: got %b want %b", obs(), ev); end
        drive(COND_GT, 1, 0, 0, 0, 2'b11, 4'b1000, 0, 0);
        sb.push_back(12'b0_0_0_0_1000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL gt_fail: got %b want %b", obs(), ev); end
        drive(COND_AL, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0);
        sb.push_back(12'b1_0_0_0_1000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL gt_no_flags: got %b want %b", obs(), ev); end
        drive(COND_AL, 0, 0, 0, 0, 2'b11, 4'b0000, 0, 0);
        sb.push_back(12'b1_0_0_0_1000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL set2_issue: got %b want %b", obs(), ev); end
        drive(COND_GT, 1, 0, 0, 0, 2'b00, 4'b1001, 0, 0);
        sb.push_back({F, F, 2'b00, 4'b1001, 4'b0000});
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL gt_pass: got %b want %b", obs(), ev); end
    endtask
    task automatic test_flush_stall();
        do_reset();
        drive(COND_AL, 0, 0, 1, 0, 2'b00, 4'b0000, 0, 0);
        sb.push_back(12'b1_0_0_1_0000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL branch_taken: got %b want %b", obs(), ev); end
        drive(COND_AL, 0, 0, 1, 0, 2'b00, 4'b0000, 1, 1);
        sb.push_back(12'b1_0_0_0_0000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL flush_over_stall: got %b want %b", obs(), ev); end
        drive(COND_AL, 1, 1, 0, 1, 2'b00, 4'b0000, 0, 1);
        sb.push_back(12'b1_0_0_0_0000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL flush_only: got %b want %b", obs(), ev); end
    endtask
    task automatic test_stall_hold();
        logic [3:0] af[3] = '{4'b1000, 4'b0100, 4'b0010};
        do_reset();
        drive(COND_AL, 1, 0, 0, 0, 2'b11, 4'b0000, 0, 0);
        bus.MemtoRegD = 1'b1;
        bus.ALUSrcD = 1'b1;
        bus.ALUControlD = 2'b10;
        sb.push_back(12'b1_1_0_0_0000_1_1_10);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL hold_load: got %b want %b", obs(), ev); end
        for (int i = 0; i < 3; i++) begin
            drive(COND_NE, 0, 1, 1, 1, 2'b00, af[i], 1, 0);
            bus.ALUControlD = 2'b01;
            sb.push_back(12'b1_1_0_0_0000_1_1_10);
            tick();
            ev = sb.pop_front(); n_chk++;
            if (obs() !== ev) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b want %b", i, obs(), ev); end
        end
        drive(COND_AL, 0, 0, 0, 0, 2'b00, 4'b0110, 0, 0);
        sb.push_back(12'b1_0_0_0_0110_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL stall_release: got %b want %b", obs(), ev); end
    endtask
    task automatic test_hi_nv();
        do_reset();
        drive(COND_AL, 0, 0, 0, 0, 2'b11, 4'b0000, 0, 0);
        sb.push_back(12'b1_0_0_0_0000_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL hi_set: got %b want %b", obs(), ev); end
        drive(COND_HI, 1, 0, 0, 0, 2'b00, 4'b0010, 0, 0);
        sb.push_back({F, F, 2'b00, 4'b0010, 4'b0000});
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL hi_eval: got %b want %b", obs(), ev); end
        drive(COND_NV, 1, 1, 0, 1, 2'b11, 4'b0000, 0, 0);
        sb.push_back(12'b0_0_0_0_0010_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL nv_never: got %b want %b", obs(), ev); end
        drive(COND_AL, 0, 0, 0, 0, 2'b00, 4'b1111, 0, 0);
        sb.push_back(12'b1_0_0_0_0010_0_0_00);
        tick();
        ev = sb.pop_front(); n_chk++;
        if (obs() !== ev) begin n_fail++; $display("FAIL nv_no_flags: got %b want %b", obs(), ev); end
    endtask
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_back_to_back();
        test_gt_gating();
        test_flush_stall();
        test_stall_hold();
        test_hi_nv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
